jedro_1_shift_cmp_unit: RTL and testbench
=========================================

JEDRO_1_SHIFT_CMP_UNIT -- requirements
Module: jedro_1_shift_cmp_unit

Interface
REQ-001 Parameters SHALL be none; data width is fixed at 32 bits.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset; synchronous and active-high.
REQ-004 valid_i  input  1  operation request qualifier for the current cycle.
REQ-005 op_sel_i  input  2  operation: 2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 SLT (signed less-than).
REQ-006 opa_i  input  32  operand A: the value shifted, or the left comparand.
REQ-007 opb_i  input  32  operand B: shift amount in bits [4:0] (bits [31:5] ignored), or the right comparand.
REQ-008 res_o  output  32  registered result.
REQ-009 valid_o  output  1  registered; marks res_o as holding a new result.

Function
REQ-010 Latency SHALL be exactly one cycle: a request sampled with valid_i=1 at edge N appears on res_o with valid_o=1 after edge N; no backpressure; a new request is accepted every cycle.
REQ-011 If valid_i=0 at an edge, valid_o SHALL go to 0 and res_o SHALL hold its previous value.
REQ-012 The shift amount SHALL be sh = opb_i[4:0] (0..31); shifts of 32 or more cannot occur.
REQ-013 SLL SHALL produce opa_i << sh, with zeros filled into the low bits.
REQ-014 SRL SHALL produce opa_i >> sh, with zeros filled into the high bits.
REQ-015 SRA SHALL produce opa_i >> sh, with opa_i[31] replicated into the vacated high bits.
REQ-016 sh=0 SHALL return opa_i unchanged for all three shift operations.
REQ-017 The shifters SHALL be log-depth barrel structures: five mux stages (1, 2, 4, 8, 16), one per bit of sh.
REQ-018 SRL and SRA SHALL share one right-shift datapath; the fill bit is 0 for SRL and opa_i[31] for SRA.
REQ-019 SLT SHALL treat both operands as two's-complement signed values.
REQ-020 SLT SHALL return 32'h00000001 when opa_i < opb_i, else 32'h00000000.
REQ-021 SLT SHALL return 0 when the operands are equal.
REQ-022 SLT sign handling: if opa_i[31] and opb_i[31] differ, the result is opa_i[31]; otherwise it is the unsigned compare of bits [30:0].
REQ-023 The datapath SHALL be purely combinational between the inputs and the output register; there is no internal state other than res_o and valid_o.

Reset
REQ-024 When rst_i=1 at a rising edge, res_o SHALL become 32'h00000000 and valid_o SHALL become 0, regardless of valid_i and op_sel_i.
REQ-025 Reset SHALL take priority over a simultaneous request; a request sampled in a reset cycle is discarded.
REQ-026 On the first edge with rst_i=0 and valid_i=1, normal operation SHALL resume with the REQ-010 timing.
REQ-027 Reset asserted mid-stream SHALL discard the result pending for that edge; there is no partial update.

Verification
REQ-028 Shifts with opa=32'h80000000, opb=31: SRL -> 32'h00000001; SRA -> 32'hFFFFFFFF; SLL with opa=32'h00000001, opb=31 -> 32'h80000000.
REQ-029 Shift-amount masking: SLL, opa=32'h0000000F, opb=32'hFFFFFF24 (sh=4) -> 32'h000000F0; any op with sh=0 -> opa unchanged.
REQ-030 SRA on a positive value: opa=32'h7FFF0000, opb=8 -> 32'h007FFF00; SRL on opa=32'hF0000000, opb=4 -> 32'h0F000000.
REQ-031 SLT: (32'hFFFFFFFF, 32'h00000001) -> 1; (32'h7FFFFFFF, 32'h80000000) -> 0; (32'h80000000, 32'h7FFFFFFF) -> 1; (5, 5) -> 0.
REQ-032 Timing and reset: back-to-back valid requests give a result every cycle with latency 1; valid_i=0 holds res_o and drops valid_o; rst_i=1 together with valid_i=1 -> res_o=0 and valid_o=0 on the next cycle.

Source files
------------

// File: rtl/jedro_1_shift_cmp_unit.sv
// jedro_1_shift_cmp_unit
// Single-cycle shift / signed-compare unit with a registered 32-bit result.
// SLL, SRL and SRA use five-stage barrel shifters, and SRL/SRA share one
// right-shift datapath. SLT gives a 0/1 result from a two's-complement compare.
// The output register holds its value on idle cycles and clears on reset.

module jedro_1_shift_cmp_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [1:0]  op_sel_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic [31:0] res_o,
  output logic        valid_o
);

  // Operation encodings as seen on op_sel_i.
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  // Only the low five bits of operand B matter for shifts.
  logic [4:0]  shamt;
  assign shamt = opb_i[4:0];

  // ------------------------------------------------------------------
  // Left barrel shifter.
  // Stage gi moves the data by 2**gi bits when shamt[gi] is set.
  // Entry 0 is the raw operand and entry 5 is the fully shifted value.
  // ------------------------------------------------------------------
  logic [31:0] sll_stage [0:5];
  assign sll_stage[0] = opa_i;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi = gi + 1) begin : g_sll
      localparam int STEP = 1 << gi;
      assign sll_stage[gi+1] = shamt[gi]
        ? {sll_stage[gi][31-STEP:0], {STEP{1'b0}}}
        : sll_stage[gi];
    end
  endgenerate

  // ------------------------------------------------------------------
  // Shared right barrel shifter.
  // The fill bit is 0 for a logical shift and opa_i[31] for an arithmetic
  // shift. The same fill bit goes into every stage, so sign extension
  // carries through all five stages.
  // ------------------------------------------------------------------
  logic        right_fill;
  logic [31:0] sr_stage [0:5];

  assign right_fill  = (op_sel_i == OP_SRA) ? opa_i[31] : 1'b0;
  assign sr_stage[0] = opa_i;

  generate
    for (gi = 0; gi < 5; gi = gi + 1) begin : g_sr
      localparam int STEP = 1 << gi;
      assign sr_stage[gi+1] = shamt[gi]
        ? {{STEP{right_fill}}, sr_stage[gi][31:STEP]}
        : sr_stage[gi];
    end
  endgenerate

  // ------------------------------------------------------------------
  // Signed less-than.
  // If the signs differ, A is smaller exactly when A is negative.
  // If the signs match, the lower 31 bits decide through an unsigned
  // compare. Equal operands give 0.
  // ------------------------------------------------------------------
  logic sign_diff;
  logic mag_lt;
  logic slt_bit;

  assign sign_diff = opa_i[31] ^ opb_i[31];
  assign mag_lt    = (opa_i[30:0] < opb_i[30:0]);
  assign slt_bit   = sign_diff ? opa_i[31] : mag_lt;

  // Select the result for the requested operation.
  logic [31:0] res_next;

  always_comb begin
    res_next = 32'h0000_0000;
    case (op_sel_i)
      OP_SLL:  res_next = sll_stage[5];
      OP_SRL:  res_next = sr_stage[5];
      OP_SRA:  res_next = sr_stage[5];
      OP_SLT:  res_next = {31'b0, slt_bit};
      default: res_next = 32'h0000_0000;
    endcase
  end

  // ------------------------------------------------------------------
  // Output register.
  // Reset has priority over a request in the same cycle and discards it.
  // An idle cycle drops valid and keeps the last result.
  // ------------------------------------------------------------------
  logic [31:0] res_reg;
  logic        valid_reg;

  // Capture the result on a request; clear both registers on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_reg   <= 32'h0000_0000;
      valid_reg <= 1'b0;
    end else if (valid_i) begin
      res_reg   <= res_next;
      valid_reg <= 1'b1;
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign res_o   = res_reg;
  assign valid_o = valid_reg;

endmodule

// File: tb/tb_jedro_1_shift_cmp_unit.sv
// Testbench for jedro_1_shift_cmp_unit.
// It starts with directed corner vectors and then runs random traffic
// with idle cycles and reset pulses mixed in.

module tb_jedro_1_shift_cmp_unit;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [1:0]  op_sel;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] res;
  logic        valid_out;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Expected state of the output register.
  logic [31:0] exp_res;
  logic        exp_valid;

  jedro_1_shift_cmp_unit dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (valid_in),
    .op_sel_i (op_sel),
    .opa_i    (opa),
    .opb_i    (opb),
    .res_o    (res),
    .valid_o  (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Compute the result from the operation's definition in plain arithmetic.
  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int unsigned sh;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sh = b % 32;
    sa = a;
    sb = b;
    case (op)
      2'd0:    return a << sh;
      2'd1:    return a >> sh;
      2'd2:    return sa >>> sh;
      default: return (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Apply one cycle of inputs, update the model and check both outputs.
  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b, input string tag);
    rst      = r;
    valid_in = v;
    op_sel   = op;
    opa      = a;
    opb      = b;
    @(posedge clk);
    if (r) begin
      exp_res   = 32'd0;
      exp_valid = 1'b0;
    end else if (v) begin
      exp_res   = ref_op(op, a, b);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
    check({tag, ".res"}, res, exp_res);
    check({tag, ".valid"}, {31'b0, valid_out}, {31'b0, exp_valid});
    $display("txn %s rst=%0b v=%0b op=%0d a=%08h b=%08h -> res=%08h valid=%0b",
             tag, r, v, op, a, b, res, valid_out);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        r;
    logic        v;
    exp_res   = 32'd0;
    exp_valid = 1'b0;
    rst = 1'b1; valid_in = 1'b0; op_sel = 2'd0; opa = 32'd0; opb = 32'd0;
    @(posedge clk); #1;

    // Reset together with a request: the request must be dropped.
    step(1'b1, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'd3, "reset_with_req");

    // Shift corners at the maximum amount.
    step(1'b0, 1'b1, 2'd1, 32'h8000_0000, 32'd31, "srl31");
    step(1'b0, 1'b1, 2'd2, 32'h8000_0000, 32'd31, "sra31");
    step(1'b0, 1'b1, 2'd0, 32'h0000_0001, 32'd31, "sll31");
    // Bits above [4:0] must not affect the shift amount, and sh=0 returns A.
    step(1'b0, 1'b1, 2'd0, 32'h0000_000F, 32'hFFFF_FF24, "sll_mask");
    step(1'b0, 1'b1, 2'd0, 32'hA5A5_1234, 32'hFFFF_FFE0, "sll_sh0");
    step(1'b0, 1'b1, 2'd1, 32'hA5A5_1234, 32'h0000_0020, "srl_sh0");
    step(1'b0, 1'b1, 2'd2, 32'hA5A5_1234, 32'd0, "sra_sh0");
    step(1'b0, 1'b1, 2'd2, 32'h7FFF_0000, 32'd8, "sra_pos");
    step(1'b0, 1'b1, 2'd1, 32'hF000_0000, 32'd4, "srl_neg");
    // Signed compare corners.
    step(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0001, "slt_m1_1");
    step(1'b0, 1'b1, 2'd3, 32'h7FFF_FFFF, 32'h8000_0000, "slt_max_min");
    step(1'b0, 1'b1, 2'd3, 32'h8000_0000, 32'h7FFF_FFFF, "slt_min_max");
    step(1'b0, 1'b1, 2'd3, 32'd5, 32'd5, "slt_eq");
    // An idle cycle keeps the last result and drops valid.
    step(1'b0, 1'b1, 2'd2, 32'hC000_0000, 32'd2, "pre_idle");
    step(1'b0, 1'b0, 2'd0, 32'h1234_5678, 32'd1, "idle_hold");
    step(1'b0, 1'b0, 2'd3, 32'h0, 32'h1, "idle_hold2");
    // Reset in the middle of a stream, then resume on the next cycle.
    step(1'b0, 1'b1, 2'd0, 32'h0000_00FF, 32'd8, "pre_rst");
    step(1'b1, 1'b1, 2'd0, 32'h0000_00FF, 32'd4, "mid_rst");
    step(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'd16, "resume");

    // Random traffic with about 10% idle cycles and 3% reset cycles.
    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: b[4:0] = 5'd0;
        1: b[4:0] = 5'd31;
        2: a = b;
        3: a[31] = ~b[31];
        default: ;
      endcase
      r = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) >= 10);
      step(r, v, op, a, b, "rand");
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
